// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, TX/RX state encodings and the divisor helper.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_RXDATA  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_TX_OVR   = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_RX_OVR   = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // A divisor of 0 would never reach a bit boundary, so it behaves as 1.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. A push while full is accepted only when a pop
// happens in the same cycle (the freed slot is reused, occupancy unchanged).
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART on the data-memory bus with combinational loads.
// Define MMIO_UART_RX_EN to build the receiver and its RXDATA/STATUS state.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [3:0]  BASE_NIBBLE = 4'h4,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);

  logic        sel;
  logic [1:0]  rsel;
  logic        wr_tx, wr_status, wr_baud;
  logic [15:0] bauddiv_reg;
  logic        tx_ovr_reg;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic        rx_valid, rx_ovr;
  logic [7:0]  rx_byte;

  assign sel       = (addr[31:28] == BASE_NIBBLE);
  assign rsel      = addr[3:2];
  assign wr_tx     = sel & we & wmask[0] & (rsel == REG_TXDATA);
  assign wr_status = sel & we & wmask[0] & (rsel == REG_STATUS);
  assign wr_baud   = sel & we & (rsel == REG_BAUDDIV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bauddiv_reg <= DEFAULT_DIV;
    end else if (wr_baud) begin
      if (wmask[0]) bauddiv_reg[7:0]  <= wdata[7:0];
      if (wmask[1]) bauddiv_reg[15:8] <= wdata[15:8];
    end
  end

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  tx_ovr_reg <= 1'b0;
    else if (wr_tx & fifo_full & ~fifo_pop)      tx_ovr_reg <= 1'b1;
    else if (wr_status & wdata[ST_TX_OVR])       tx_ovr_reg <= 1'b0;
  end

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_div_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_bit_end;

  assign tx_bit_end = (tx_cnt_reg == tx_div_reg - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state_reg <= TX_IDLE;
    else        tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    case (tx_state_reg)
      TX_IDLE:  if (!fifo_empty) tx_state_next = TX_START;
      TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_state_next = fifo_empty ? TX_IDLE : TX_START;
      default:  tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = ((tx_state_reg == TX_IDLE) | ((tx_state_reg == TX_STOP) & tx_bit_end))
               & ~fifo_empty;
    case (tx_state_reg)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift_reg[0];
      default:  tx = 1'b1;
    endcase
  end

  // Divisor is captured at pop so BAUDDIV writes only affect later frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt_reg   <= '0;
      tx_div_reg   <= eff_div(DEFAULT_DIV);
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
    end else if (fifo_pop) begin
      tx_cnt_reg   <= '0;
      tx_div_reg   <= eff_div(bauddiv_reg);
      tx_shift_reg <= fifo_dout;
      tx_bit_reg   <= '0;
    end else if (tx_state_reg != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt_reg <= '0;
        if (tx_state_reg == TX_DATA) begin
          tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
          tx_bit_reg   <= tx_bit_reg + 3'd1;
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end
    end
  end

  // ---------------- receiver ----------------
`ifdef MMIO_UART_RX_EN
  rx_state_e   rx_state_reg, rx_state_next;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [15:0] rx_cnt_reg, rx_div, rx_half;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg, rx_byte_reg;
  logic        rx_valid_reg, rx_ovr_reg;
  logic        rx_bit_end, rx_half_hit, rx_sample, rx_good, rx_read;

  assign rx_div      = eff_div(bauddiv_reg);
  assign rx_half     = rx_div >> 1;
  assign rx_bit_end  = (rx_cnt_reg == rx_div - 16'd1);
  assign rx_half_hit = (rx_state_reg == RX_START) & (rx_cnt_reg == rx_half);
  assign rx_read     = sel & re & (rsel == REG_RXDATA) & rx_valid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state_reg <= RX_IDLE;
    else        rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    case (rx_state_reg)
      RX_IDLE:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
      RX_START: if (rx_half_hit) rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_sample = (rx_state_reg == RX_DATA) & rx_bit_end;
    rx_good   = (rx_state_reg == RX_STOP) & rx_bit_end & rx_sync_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      if (rx_state_reg == RX_IDLE || rx_half_hit ||
          (rx_bit_end && (rx_state_reg == RX_DATA || rx_state_reg == RX_STOP)))
        rx_cnt_reg <= '0;
      else
        rx_cnt_reg <= rx_cnt_reg + 16'd1;
      if (rx_half_hit) rx_bit_reg <= '0;
      if (rx_sample) begin
        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_ovr_reg   <= 1'b0;
    end else begin
      if (rx_good && !rx_valid_reg) begin
        rx_byte_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rx_read) begin
        rx_valid_reg <= 1'b0;
      end
      if (rx_good && rx_valid_reg)                rx_ovr_reg <= 1'b1;
      else if (wr_status && wdata[ST_RX_OVR])     rx_ovr_reg <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_reg;
  assign rx_ovr   = rx_ovr_reg;
  assign rx_byte  = rx_byte_reg;

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[27:4], addr[1:0], wdata[31:16]};
`else
  assign rx_valid = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_byte  = 8'd0;

  logic unused_bits;
  assign unused_bits = &{1'b0, rx, addr[27:4], addr[1:0], wdata[31:16]};
`endif

  // ---------------- load path ----------------
  always_comb begin
    rdata = '0;
    if (sel && re) begin
      case (rsel)
        REG_STATUS: begin
          rdata[ST_TX_FULL]  = fifo_full;
          rdata[ST_TX_BUSY]  = (tx_state_reg != TX_IDLE) | ~fifo_empty;
          rdata[ST_TX_OVR]   = tx_ovr_reg;
          rdata[ST_RX_VALID] = rx_valid;
          rdata[ST_RX_OVR]   = rx_ovr;
        end
        REG_RXDATA:  rdata = {rx_valid, 23'd0, rx_byte};
        REG_BAUDDIV: rdata = {16'd0, bauddiv_reg};
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Self-checking bench for mmio_uart: register table, directed TX/RX frames and
// randomized TX traffic compared against an ideal 8N1 waveform model.
module tb_mmio_uart;

  localparam int LOGN = 40000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart #(.BASE_NIBBLE(4'h4), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wmask (wmask),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .tx    (tx),
    .rx    (rx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tx as seen during the cycle following posedge number cyc
  bit txlog [LOGN];
  always @(negedge clk) if (cyc < LOGN) txlog[cyc] = tx;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output int e);
    addr = a; wdata = d; wmask = m; we = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    we = 1'b0; wmask = '0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    #1 d = rdata;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Frames are expected back-to-back starting at logged cycle 'start'.
  task automatic check_frames(input string name, input int start, input int d,
                              input logic [7:0] q[$]);
    int mism, lows, tail;
    for (int f = 0; f < q.size(); f++) begin
      mism = (f == 0 && txlog[start-1] != 1'b1) ? 1 : 0;
      for (int j = 0; j < 10*d; j++)
        if (txlog[start + f*10*d + j] != frame_bit(q[f], j / d)) mism++;
      chk($sformatf("%s frame%0d(0x%02h) bad cycles", name, f, q[f]), mism, 0);
    end
    tail = start + q.size()*10*d;
    lows = 0;
    for (int j = 0; j < 3; j++) if (txlog[tail + j] != 1'b1) lows++;
    chk($sformatf("%s idle after frames", name), lows, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input int d);
    for (int k = 0; k < 10; k++) begin
      rx = frame_bit(b, k);
      repeat (d) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [7:0]  q[$];
    logic [31:0] rd;
    int          e, e0, lows, d, deff, n, first;
    logic [3:0]  nib, m;
    logic [7:0]  b;
    logic [31:0] a;

    #23 reset = 1'b1;
    @(posedge clk); #1;

    // ---- reset in the middle of a frame ----
    store(32'h4000_0000, 32'h55, 4'h1, e);
    repeat (20) @(posedge clk);
    #1 chk("tx in start bit", tx, 0);
    #2 reset = 1'b0;
    #1 chk("tx high on async reset", tx, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    load(32'h4000_0004, rd); chk("STATUS after reset", rd, 32'h0);
    load(32'h4000_000C, rd); chk("BAUDDIV after reset", rd, 32'd868);
    lows = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
    chk("tx idle after reset (low cycles)", lows, 0);

    // ---- register access table ----
    vecs.push_back('{1'b1, 1'b0, 32'h4000_000C, 32'h0000_1234, 4'b0011, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_000C, 32'h0,         4'b0000, 32'h1234});
    vecs.push_back('{1'b1, 1'b0, 32'h4000_000C, 32'hFFFF_FF56, 4'b0001, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4123_456F, 32'h0,         4'b0000, 32'h1256});
    vecs.push_back('{1'b0, 1'b0, 32'h4000_000C, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h5000_000C, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_0000, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h4000_000C, 32'hAB00_0000, 4'b1100, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_000C, 32'h0,         4'b0000, 32'h1256});
    vecs.push_back('{1'b1, 1'b0, 32'h4000_0000, 32'h0000_00FF, 4'b0010, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_0004, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h5000_0008, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_0008, 32'h0,         4'b0000, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h4000_000C, 32'h0,         4'b0011, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h4000_000C, 32'h0,         4'b0000, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      addr = vecs[i].addr; wdata = vecs[i].wdata; wmask = vecs[i].wmask;
      we = vecs[i].we; re = vecs[i].re;
      #1 chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp);
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0; wmask = '0;
    end
    lows = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
    chk("tx idle after masked store (low cycles)", lows, 0);

    // ---- single frame 0xA5 at div 4; BAUDDIV change mid-frame ----
    store(32'h4000_000C, 32'd4, 4'b0011, e);
    store(32'h4000_0000, 32'hA5, 4'b0001, e0);
    store(32'h4000_000C, 32'd2, 4'b0011, e);
    wait_until(e0 + 1 + 40 + 4);
    q = '{8'hA5};
    check_frames("a5", e0 + 1, 4, q);
    store(32'h4000_0000, 32'h3C, 4'b0001, e0);
    wait_until(e0 + 1 + 20 + 4);
    q = '{8'h3C};
    check_frames("div2", e0 + 1, 2, q);

    // ---- fill, overflow, W1C and back-to-back frames ----
    store(32'h4000_000C, 32'd4, 4'b0011, e);
    q = {};
    for (int i = 0; i < 9; i++) begin
      b = 8'(i * 37 + 3);
      store(32'h4000_0000, {24'hFFFFFF, b}, 4'b0001, e);
      if (i == 0) e0 = e;
      q.push_back(b);
    end
    load(32'h4000_0004, rd); chk("STATUS full after 9 stores", rd, 32'h3);
    store(32'h4000_0000, 32'hEE, 4'b0001, e);
    load(32'h4000_0004, rd); chk("STATUS overflow after 10th", rd, 32'h7);
    store(32'h4000_0004, 32'h4, 4'b0001, e);
    load(32'h4000_0004, rd); chk("STATUS after W1C tx_ovr", rd, 32'h3);
    wait_until(e0 + 1 + 9*40 + 4);
    check_frames("b2b", e0 + 1, 4, q);
    load(32'h4000_0004, rd); chk("STATUS idle after burst", rd, 32'h0);

    // ---- randomized TX traffic ----
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 5);
      deff = (d == 0) ? 1 : d;
      store(32'h4000_000C, 32'(d), 4'b0011, e);
      q = {}; first = -1;
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        nib = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'h4;
        a   = {nib, 24'($urandom), 2'b00, 2'($urandom)};
        m   = 4'($urandom);
        b   = 8'($urandom);
        store(a, {24'($urandom), b}, m, e);
        if (nib == 4'h4 && m[0]) begin
          if (first < 0) first = e;
          q.push_back(b);
        end
      end
      if (q.size() > 0) begin
        wait_until(first + 1 + q.size()*10*deff + 4);
        check_frames($sformatf("rand%0d", it), first + 1, deff, q);
      end else begin
        lows = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
        chk($sformatf("rand%0d no push (low cycles)", it), lows, 0);
      end
    end

    // ---- receiver ----
    store(32'h4000_000C, 32'd8, 4'b0011, e);
`ifdef MMIO_UART_RX_EN
    send_rx(8'h3C, 8);
    load(32'h4000_0008, rd); chk("RXDATA first read", rd, 32'h8000_003C);
    load(32'h4000_0008, rd); chk("RXDATA second read", rd, 32'h0000_003C);
    send_rx(8'h3C, 8);
    send_rx(8'h11, 8);
    load(32'h4000_0004, rd); chk("STATUS rx overrun", rd, 32'h18);
    load(32'h4000_0008, rd); chk("RXDATA kept first byte", rd, 32'h8000_003C);
    store(32'h4000_0004, 32'h10, 4'b0001, e);
    load(32'h4000_0004, rd); chk("STATUS after W1C rx_ovr", rd, 32'h0);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    load(32'h4000_0004, rd); chk("STATUS after glitch", rd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_rx(b, 8);
      load(32'h4000_0008, rd); chk($sformatf("RXDATA random%0d", i), rd, {1'b1, 23'd0, b});
    end
`else
    send_rx(8'h3C, 8);
    load(32'h4000_0008, rd); chk("RXDATA without receiver", rd, 32'h0);
    load(32'h4000_0004, rd); chk("STATUS without receiver", rd, 32'h0);
    store(32'h4000_0004, 32'h14, 4'b0001, e);
    load(32'h4000_0004, rd); chk("STATUS after W1C without receiver", rd, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
